fetch_unit: RTL and testbench

Instruction-fetch stage of the simplified MIPS datapath. It holds the program counter and drives the instruction memory's byte address. It captures the returned 32-bit word into the IF/ID pipeline register for the decode stage. It also applies sequential, branch and jump next-PC selection, plus stall and flush control coming back from decode.

---
 rtl/fetch_unit.sv | 90 +++++++++
 tb/tb_fetch_unit.sv | 135 +++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC selection (sequential/branch/jump)
// and the IF/ID pipeline register, with stall and redirect-squash control.
module fetch_unit #(
  parameter int unsigned           ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] Read_address,
  input  logic [31:0]           Instruction,
  input  logic                  Stall,
  input  logic                  Branch_taken,
  input  logic [15:0]           Branch_offset,
  input  logic                  Jump,
  input  logic [25:0]           Jump_index,
  output logic [31:0]           ID_instruction,
  output logic [ADDR_WIDTH-1:0] ID_pc_plus4,
  output logic                  ID_valid
);

  localparam logic [ADDR_WIDTH-1:0] PcStep = ADDR_WIDTH'(4);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]           id_instr_q, id_instr_d;
  logic [ADDR_WIDTH-1:0] id_pc4_q, id_pc4_d;
  logic                  id_valid_q, id_valid_d;

  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic [31:0]           branch_disp;
  logic [ADDR_WIDTH-1:0] branch_target;
  logic [ADDR_WIDTH-1:0] jump_target;
  logic                  jump_ok, branch_ok, redirect;
  logic                  unused_bits;

  assign pc_plus4      = pc_q + PcStep;
  assign branch_disp   = {{14{Branch_offset[15]}}, Branch_offset, 2'b00};
  assign branch_target = id_pc4_q + branch_disp[ADDR_WIDTH-1:0];
  assign jump_target   = {Jump_index[ADDR_WIDTH-3:0], 2'b00};
  assign unused_bits   = ^{Jump_index[25:ADDR_WIDTH-2], branch_disp[31:ADDR_WIDTH]};

  // Only a real, non-stalled instruction in decode may redirect fetch.
  assign jump_ok   = Jump & id_valid_q & ~Stall;
  assign branch_ok = Branch_taken & id_valid_q & ~Stall;
  assign redirect  = jump_ok | branch_ok;

  always_comb begin
    pc_d       = pc_q;
    id_instr_d = id_instr_q;
    id_pc4_d   = id_pc4_q;
    id_valid_d = id_valid_q;
    if (!Stall) begin
      if (jump_ok) begin
        pc_d = jump_target;
      end else if (branch_ok) begin
        pc_d = branch_target;
      end else begin
        pc_d = pc_plus4;
      end
      // Squash the wrong-path word fetched in the redirect cycle.
      if (redirect) begin
        id_instr_d = '0;
        id_valid_d = 1'b0;
      end else begin
        id_instr_d = Instruction;
        id_pc4_d   = pc_plus4;
        id_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      id_instr_q <= '0;
      id_pc4_q   <= '0;
      id_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      id_instr_q <= id_instr_d;
      id_pc4_q   <= id_pc4_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign Read_address   = pc_q;
  assign ID_instruction = id_instr_q;
  assign ID_pc_plus4    = id_pc4_q;
  assign ID_valid       = id_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a word-addressed memory model.
module tb_fetch_unit;

  localparam int unsigned AW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] Read_address;
  logic [31:0]   Instruction;
  logic          Stall;
  logic          Branch_taken;
  logic [15:0]   Branch_offset;
  logic          Jump;
  logic [25:0]   Jump_index;
  logic [31:0]   ID_instruction;
  logic [AW-1:0] ID_pc_plus4;
  logic          ID_valid;

  logic [31:0] mem [1024];
  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit #(
    .ADDR_WIDTH(AW),
    .RESET_PC  ('0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .Read_address  (Read_address),
    .Instruction   (Instruction),
    .Stall         (Stall),
    .Branch_taken  (Branch_taken),
    .Branch_offset (Branch_offset),
    .Jump          (Jump),
    .Jump_index    (Jump_index),
    .ID_instruction(ID_instruction),
    .ID_pc_plus4   (ID_pc_plus4),
    .ID_valid      (ID_valid)
  );

  always #5 clk = ~clk;

  assign Instruction = mem[Read_address[AW-1:2]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [31:0] ra, input logic [31:0] ins,
                           input logic [31:0] pc4, input logic vld);
    check({tag, ".ra"},    32'(Read_address),   ra);
    check({tag, ".ins"},   ID_instruction,      ins);
    check({tag, ".pc4"},   32'(ID_pc_plus4),    pc4);
    check({tag, ".valid"}, 32'(ID_valid),       32'(vld));
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | i;
    mem[0] = 32'h1111_1111;
    mem[1] = 32'h2222_2222;
    mem[2] = 32'h3333_3333;
    reset = 1'b1; Stall = 1'b0; Branch_taken = 1'b0; Branch_offset = '0;
    Jump = 1'b0; Jump_index = '0;

    #2;
    check_all("reset", 32'h000, 32'h0, 32'h000, 1'b0);
    #10;
    reset = 1'b0;

    // Free-run from reset
    step(); check_all("e1", 32'h004, 32'h1111_1111, 32'h004, 1'b1);
    step(); check_all("e2", 32'h008, 32'h2222_2222, 32'h008, 1'b1);

    // Stall 3 cycles at PC=8
    Stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(); check_all("stall", 32'h008, 32'h2222_2222, 32'h008, 1'b1);
    end
    Stall = 1'b0;
    step(); check_all("resume", 32'h00C, 32'h3333_3333, 32'h00C, 1'b1);
    step(); check_all("e7", 32'h010, 32'hA000_0003, 32'h010, 1'b1);

    // Taken branch: 0x010 + (-2 << 2) = 0x008
    Branch_taken = 1'b1; Branch_offset = 16'hFFFE;
    step(); check_all("br", 32'h008, 32'h0, 32'h010, 1'b0);
    // Still asserted while ID_valid=0: must be ignored
    step(); check_all("br_inval", 32'h00C, 32'h3333_3333, 32'h00C, 1'b1);

    // Branch during stall is ignored
    Stall = 1'b1;
    step(); check_all("br_stall", 32'h00C, 32'h3333_3333, 32'h00C, 1'b1);
    Stall = 1'b0; Branch_taken = 1'b0;
    step(); check_all("post_stall", 32'h010, 32'hA000_0003, 32'h010, 1'b1);

    // Jump wins over simultaneous branch: {0x123, 2'b00} = 0x48C
    Jump = 1'b1; Jump_index = 26'h000_0123; Branch_taken = 1'b1;
    step(); check_all("jmp", 32'h48C, 32'h0, 32'h010, 1'b0);
    Jump = 1'b0; Branch_taken = 1'b0;
    step(); check_all("jmp_tgt", 32'h490, 32'hA000_0123, 32'h490, 1'b1);

    // PC wrap-around at 0xFFC
    Jump = 1'b1; Jump_index = 26'h000_03FF;
    step(); check_all("jmp_ffc", 32'hFFC, 32'h0, 32'h490, 1'b0);
    Jump = 1'b0;
    step(); check_all("wrap", 32'h000, 32'hA000_03FF, 32'h000, 1'b1);

    // Get to PC=0x020, then asynchronous reset mid-cycle
    Jump = 1'b1; Jump_index = 26'h000_0008;
    step(); check_all("jmp_20", 32'h020, 32'h0, 32'h000, 1'b0);
    Jump = 1'b0;
    step(); check_all("at_24", 32'h024, 32'hA000_0008, 32'h024, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_all("async_rst", 32'h000, 32'h0, 32'h000, 1'b0);
    step(); check_all("rst_hold", 32'h000, 32'h0, 32'h000, 1'b0);
    #3;
    reset = 1'b0;
    step(); check_all("restart", 32'h004, 32'h1111_1111, 32'h004, 1'b1);
    step(); check_all("restart2", 32'h008, 32'h2222_2222, 32'h008, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
